// File: rtl/change_dispenser.sv
// Greedy coin payout controller: pays a cent amount as timed quarter/dime/nickel
// actuator pulses, skipping empty hoppers, then reports the unpaid residue.
`timescale 1ns/1ps
module change_dispenser #(
   parameter int WIDTH        = 32,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] amount,
   input  logic             quarter_empty,
   input  logic             dime_empty,
   input  logic             nickel_empty,
   output logic             out_quarter,
   output logic             out_dime,
   output logic             out_nickel,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [WIDTH-1:0] residue,
   output logic [7:0]       coin_count
);

   localparam int T_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYCLES - 1);
   localparam logic [WIDTH-1:0] Q_VAL      = WIDTH'(25);
   localparam logic [WIDTH-1:0] D_VAL      = WIDTH'(10);
   localparam logic [WIDTH-1:0] N_VAL      = WIDTH'(5);

   typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

   state_t           r_state,     w_state;
   logic [WIDTH-1:0] r_remaining, w_remaining;
   logic [TW-1:0]    r_timer,     w_timer;
   logic [2:0]       r_out,       w_out;   // one-hot {quarter, dime, nickel}
   logic             r_busy,      w_busy;
   logic             r_done,      w_done;
   logic             r_short,     w_short;
   logic [WIDTH-1:0] r_residue,   w_residue;
   logic [7:0]       r_count,     w_count;

   // NOTE: every w_* gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      w_state     = r_state;
      w_remaining = r_remaining;
      w_timer     = r_timer;
      w_out       = r_out;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_short     = r_short;
      w_residue   = r_residue;
      w_count     = r_count;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               w_remaining = amount;
               w_short     = 1'b0;
               w_residue   = '0;
               w_count     = '0;
               w_busy      = 1'b1;
               w_state     = SELECT;
            end
         end
         SELECT: begin
            if (r_remaining >= Q_VAL && !quarter_empty) begin
               w_out       = 3'b100;
               w_remaining = r_remaining - Q_VAL;
            end else if (r_remaining >= D_VAL && !dime_empty) begin
               w_out       = 3'b010;
               w_remaining = r_remaining - D_VAL;
            end else if (r_remaining >= N_VAL && !nickel_empty) begin
               w_out       = 3'b001;
               w_remaining = r_remaining - N_VAL;
            end
            if (w_out != 3'b000) begin
               w_count = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
               w_timer = PULSE_LOAD;
               w_state = PULSE;
            end else begin
               // Residue and short are registered alongside done so all three align.
               w_done    = 1'b1;
               w_residue = r_remaining;
               w_short   = (r_remaining != '0);
               w_state   = DONE;
            end
         end
         PULSE: begin
            if (r_timer == '0) begin
               w_out   = 3'b000;
               w_timer = GAP_LOAD;
               w_state = GAP;
            end else begin
               w_timer = r_timer - 1'b1;
            end
         end
         GAP: begin
            if (r_timer == '0) w_state = SELECT;
            else               w_timer = r_timer - 1'b1;
         end
         DONE: begin
            w_busy  = 1'b0;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_timer     <= '0;
         r_out       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_short     <= 1'b0;
         r_residue   <= '0;
         r_count     <= '0;
      end else begin
         r_state     <= w_state;
         r_remaining <= w_remaining;
         r_timer     <= w_timer;
         r_out       <= w_out;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_short     <= w_short;
         r_residue   <= w_residue;
         r_count     <= w_count;
      end
   end

   assign out_quarter = r_out[2];
   assign out_dime    = r_out[1];
   assign out_nickel  = r_out[0];
   assign busy        = r_busy;
   assign done        = r_done;
   assign short       = r_short;
   assign residue     = r_residue;
   assign coin_count  = r_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, pulse/gap timing, latency,
// residue reporting, ignored starts and asynchronous reset mid-pulse.
`timescale 1ns/1ps
module tb_change_dispenser;

   localparam int WIDTH  = 32;
   localparam int PULSE  = 4;
   localparam int GAP    = 4;
   localparam int PERIOD = 1 + PULSE + GAP;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] amount;
   logic             quarter_empty, dime_empty, nickel_empty;
   logic             out_quarter, out_dime, out_nickel;
   logic             busy, done, short;
   logic [WIDTH-1:0] residue;
   logic [7:0]       coin_count;

   int n_checks = 0;
   int n_fail   = 0;

   change_dispenser #(.WIDTH(WIDTH), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset(reset), .start(start), .amount(amount),
      .quarter_empty(quarter_empty), .dime_empty(dime_empty), .nickel_empty(nickel_empty),
      .out_quarter(out_quarter), .out_dime(out_dime), .out_nickel(out_nickel),
      .busy(busy), .done(done), .short(short), .residue(residue), .coin_count(coin_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Coin sequence packed base-4: Q=1, D=2, N=3, first coin most significant.
   function automatic int seq_code(input string s);
      int r = 0;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "Q":     r = r * 4 + 1;
            "D":     r = r * 4 + 2;
            default: r = r * 4 + 3;
         endcase
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Starts a transaction and watches every cycle until done. Optionally
   // re-pulses start while busy (at cycle inject_at) and in the done cycle.
   task automatic run_txn(input string name, input int amt, input string exp_seq,
                          input int exp_res, input int exp_cnt,
                          input int inject_at, input bit inject_done);
      int c = 1, ncoin = 0, run = 0, gap_len = 0, bad = 0, first_rise = -1;
      int seq = 0, cc, pc = 0, busy_lo = 0, done_at = -1;
      amount = amt;
      start  = 1'b1;
      step();
      start  = 1'b0;
      while (c < 400 && done_at < 0) begin
         case ({out_quarter, out_dime, out_nickel})
            3'b000:  cc = 0;
            3'b100:  cc = 1;
            3'b010:  cc = 2;
            3'b001:  cc = 3;
            default: begin cc = 0; bad++; end
         endcase
         if (!busy) busy_lo++;
         if (cc != 0 && pc == 0) begin
            ncoin++;
            seq = seq * 4 + cc;
            if (ncoin == 1) first_rise = c;
            // Between pulses the outputs stay low for the gap plus the SELECT cycle.
            else if (gap_len != GAP + 1) bad++;
            run = 1;
         end else if (cc != 0 && cc == pc) begin
            run++;
         end else if (cc != 0) begin
            bad++;
         end
         if (cc == 0 && pc != 0) begin
            if (run != PULSE) bad++;
            gap_len = 1;
         end else if (cc == 0) begin
            gap_len++;
         end
         pc = cc;
         if (done) begin
            done_at = c;
         end else begin
            if (c == inject_at) begin
               start  = 1'b1;
               amount = 100;
            end
            step();
            start = 1'b0;
            c++;
         end
      end
      check({name, " done_seen"}, done_at >= 0, 1);
      check({name, " latency"}, done_at, 2 + PERIOD * exp_seq.len());
      check({name, " coin_seq"}, seq, seq_code(exp_seq));
      check({name, " timing_errs"}, bad, 0);
      check({name, " busy_while_active"}, busy_lo, 0);
      if (exp_seq.len() > 0) check({name, " first_rise"}, first_rise, 2);
      check({name, " residue"}, residue, exp_res);
      check({name, " short"}, short, exp_res != 0);
      check({name, " coin_count"}, coin_count, exp_cnt);
      if (inject_done) begin
         start  = 1'b1;
         amount = 100;
      end
      step();
      start = 1'b0;
      check({name, " busy_after"}, busy, 0);
      check({name, " done_one_cycle"}, done, 0);
      check({name, " residue_held"}, residue, exp_res);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      amount = '0;
      quarter_empty = 1'b0;
      dime_empty = 1'b0;
      nickel_empty = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset outputs", {out_quarter, out_dime, out_nickel, busy, done, short}, 0);
      check("reset residue", residue, 0);
      check("reset coin_count", coin_count, 0);
      @(negedge clock);
      reset = 1'b0;
      step();

      run_txn("amt40", 40, "QDN", 0, 3, -1, 1'b0);
      run_txn("amt0", 0, "", 0, 0, -1, 1'b0);
      run_txn("amt42", 42, "QDN", 2, 3, -1, 1'b0);

      quarter_empty = 1'b1;
      run_txn("qempty50", 50, "DDDDD", 0, 5, -1, 1'b0);
      dime_empty   = 1'b1;
      nickel_empty = 1'b1;
      run_txn("allempty30", 30, "", 30, 0, -1, 1'b0);
      quarter_empty = 1'b0;
      dime_empty    = 1'b0;
      nickel_empty  = 1'b0;

      // Restart attempts mid-pulse and in the done cycle must be ignored; the
      // following transaction starts in the cycle right after done.
      run_txn("restart40", 40, "QDN", 0, 3, 5, 1'b1);
      run_txn("backtoback15", 15, "DN", 0, 2, -1, 1'b0);

      amount = 75;
      start  = 1'b1;
      step();
      start  = 1'b0;
      repeat (11) step();
      check("rst75 second pulse", out_quarter, 1);
      check("rst75 count before", coin_count, 2);
      #2 reset = 1'b1;
      #1;
      check("rst75 async outputs", {out_quarter, out_dime, out_nickel, busy, done, short}, 0);
      check("rst75 async count", coin_count, 0);
      check("rst75 async residue", residue, 0);
      @(negedge clock);
      reset = 1'b0;
      step();
      check("rst75 no done", {done, busy}, 0);
      run_txn("after_rst25", 25, "Q", 0, 1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side counterpart of the coin-acceptor/credit path. It takes a credit amount in cents and pays it out as a sequence of timed actuator pulses, one coin at a time, for the quarter, dime and nickel hoppers.
- The controller pulses `start` with the amount to refund. The dispenser pays out greedily, highest coin first, and falls back to smaller coins when a hopper reports empty.
- It then reports completion and any amount it could not pay.

Parameters:
- WIDTH, 32, width of amount and remaining/residue values in cents.
- PULSE_CYCLES, 4, clock cycles each coin actuator output is held high (>=1).
- GAP_CYCLES, 4, clock cycles of idle time between consecutive coin pulses (>=1).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- amount  input  WIDTH  cents to dispense; latched when start is accepted.
- quarter_empty  input  1  quarter hopper empty; quarters are not selected while high.
- dime_empty  input  1  dime hopper empty.
- nickel_empty  input  1  nickel hopper empty.
- out_quarter  output  1  quarter actuator pulse.
- out_dime  output  1  dime actuator pulse.
- out_nickel  output  1  nickel actuator pulse.
- busy  output  1  high from acceptance until done.
- done  output  1  one-cycle completion strobe.
- short  output  1  valid with done; high if residue != 0; held until next accepted start.
- residue  output  WIDTH  undispensed cents; valid with done; held until next accepted start.
- coin_count  output  8  coins dispensed in current/last transaction; saturates at 255.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, internal remaining=0, timer=0.
- All outputs are registered. At most one out_* is high in any cycle.
- Coin values: quarter 25, dime 10, nickel 5. Arithmetic is unsigned WIDTH-bit. Subtraction happens only when remaining >= coin value, so there is never underflow.
- State IDLE:
  - busy=0.
  - If start=1 at edge k: latch remaining=amount, clear short/residue/coin_count, go to SELECT.
  - busy=1 from cycle k+1.
- State SELECT (exactly 1 cycle). Choose the first eligible coin in this order:
  - quarter if remaining>=25 and !quarter_empty;
  - else dime if remaining>=10 and !dime_empty;
  - else nickel if remaining>=5 and !nickel_empty.
  - If a coin is chosen: remaining -= value, coin_count += 1 (saturating), timer=PULSE_CYCLES-1, go to PULSE.
  - If no coin is chosen: go to DONE.
  - Empty inputs are sampled only in SELECT. Changes during PULSE/GAP do not affect the coin already in flight.
- State PULSE:
  - The selected out_* is high for exactly PULSE_CYCLES consecutive cycles, starting the cycle after SELECT.
  - Then timer=GAP_CYCLES-1 and go to GAP.
- State GAP:
  - All out_* low for exactly GAP_CYCLES cycles, then go to SELECT.
- State DONE (1 cycle):
  - done=1, busy=1.
  - residue=remaining; short=(remaining!=0).
  - Next state IDLE; busy=0 from the following cycle.
- Latency:
  - amount=0: start at edge k → SELECT at k+1 → done high in cycle k+2 → busy low k+3.
  - First coin: out_* rises in cycle k+2.
  - Each coin occupies 1+PULSE_CYCLES+GAP_CYCLES cycles.
- start while busy (any non-IDLE state) is ignored; amount is not re-latched.
- A start in the same cycle as done is ignored. A start is accepted the cycle after done, i.e. back-to-back with IDLE.
- Amounts not a multiple of 5 pay out down to remainder 1–4, then finish with short=1 and residue=remainder.
- If all usable hoppers are empty, the transaction finishes with the undispensed balance in residue.
- Reset asserted mid-pulse:
  - out_* drops immediately (asynchronous).
  - No done strobe.
  - The coin is counted as lost: no residue report.

Test Plan:
- PULSE=GAP=4, amount=40, hoppers full → out_quarter 4 cycles, gap 4, out_dime 4, gap 4, out_nickel 4 → done with residue=0, short=0, coin_count=3; one and only one out_* high per pulse.
- amount=0 → done exactly 2 cycles after the start edge, no out_* activity, busy high for 2 cycles, short=0.
- amount=42 → Q, D, N pulses then done with short=1, residue=2, coin_count=3.
- quarter_empty=1, amount=50 → five out_dime pulses, no out_quarter, residue=0. Then dime_empty=1 and nickel_empty=1 with amount=30 → done with no pulses, short=1, residue=30.
- start re-pulsed with amount=100 during a 40-cent transaction → ignored; totals match 40. A start the cycle after done is accepted.
- reset asserted mid-way through the second pulse of amount=75 → all outputs 0 immediately, state IDLE. A new start with amount=25 then dispenses one quarter normally.
